// File: rtl/oneto_four_demux_buf.sv
// rtl/oneto_four_demux_buf.sv - 1-to-4 demultiplexer with a one-word holding buffer and a transfer counter per channel
// Each channel is a single-entry skid-free buffer; a full channel only back-pressures words addressed to it.
module oneto_four_demux_buf #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      sel,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [3:0]      out_valid,
  output logic [4*DW-1:0] out_data,
  input  logic [3:0]      out_ready,
  output logic [4*CW-1:0] xfer_cnt
);

  logic [3:0]    full_q, full_d;
  logic [DW-1:0] data_q [4];
  logic [DW-1:0] data_d [4];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];
  logic          accept;
  logic [3:0]    drain;
  logic [3:0]    load;

  // A full channel can still take a word if it is being drained at the same edge.
  assign in_ready = !rst && (!full_q[sel] || out_ready[sel]);
  assign accept   = in_valid && in_ready;
  assign drain    = full_q & out_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      load[sel] = 1'b1;
    end
    full_d = (full_q & ~drain) | load;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = load[i]  ? in_data            : data_q[i];
      cnt_d[i]  = drain[i] ? cnt_q[i] + CW'(1)  : cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign out_valid = full_q;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    assign out_data[g*DW +: DW] = data_q[g];
    assign xfer_cnt[g*CW +: CW] = cnt_q[g];
  end

endmodule

// File: tb/tb_oneto_four_demux_buf.sv
// tb/tb_oneto_four_demux_buf.sv - self-checking bench for oneto_four_demux_buf
// Reference model keeps each channel as a held word plus occupancy and a transfer tally.
module tb_oneto_four_demux_buf;
  localparam int DW = 8;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [31:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  bit       m_full [4];
  bit [7:0] m_data [4];
  int       m_cnt  [4];

  oneto_four_demux_buf #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 0; m_data[i] = 8'h00; m_cnt[i] = 0;
    end
  endfunction

  function automatic bit exp_ready();
    return !rst && (!m_full[sel] || out_ready[sel]);
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = m_data[i];
    return d;
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] c;
    for (int i = 0; i < 4; i++) c[i*8 +: 8] = 8'(m_cnt[i] % 256);
    return c;
  endfunction

  task automatic set_in(input logic [1:0] s, input logic v, input logic [7:0] d, input logic [3:0] r);
    sel = s; in_valid = v; in_data = d; out_ready = r;
    #1;
  endtask

  // One clock: model applies drains then the accept using pre-edge inputs.
  task automatic tick();
    bit acc;
    acc = in_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_full[i] && out_ready[i]) begin
          m_cnt[i] = (m_cnt[i] + 1) % 256;
          m_full[i] = 0;
        end
      end
      if (acc) begin
        m_data[sel] = in_data;
        m_full[sel] = 1;
      end
    end
    #1;
  endtask

  task automatic drain_all();
    set_in(2'd0, 1'b0, 8'h00, 4'b1111);
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_valid got %b want 0000", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", out_data); end
    checks++;
    if (xfer_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h want 0", xfer_cnt); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", in_ready); end
    rst = 1'b0;
    model_reset();
    set_in(2'd2, 1'b1, 8'h77, 4'b0000);
    tick();
    checks++;
    if (out_valid !== 4'b0100) begin errors++; $display("FAIL first_accept got %b want 0100", out_valid); end
    // Asynchronous reset while ch2 holds a word; no clock edge in between.
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || xfer_cnt !== 32'h0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL async_rst got v=%b c=%h r=%b want 0000/0/0", out_valid, xfer_cnt, in_ready); end
    rst = 1'b0;
    model_reset();
    set_in(2'd0, 1'b0, 8'h00, 4'b0000);
  endtask

  task automatic test_routing();
    set_in(2'd0, 1'b1, 8'hA0, 4'b0000); tick();
    set_in(2'd1, 1'b1, 8'hA1, 4'b0000); tick();
    set_in(2'd2, 1'b1, 8'hA2, 4'b0000); tick();
    set_in(2'd3, 1'b1, 8'hA3, 4'b0000); tick();
    checks++;
    if (out_valid !== 4'b1111) begin errors++; $display("FAIL route_valid got %b want 1111", out_valid); end
    checks++;
    if (out_data !== 32'hA3A2A1A0) begin errors++; $display("FAIL route_data got %h want A3A2A1A0", out_data); end
    for (int s = 0; s < 4; s++) begin
      set_in(2'(s), 1'b1, 8'hEE, 4'b0000);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL route_full_ready sel=%0d got %b want 0", s, in_ready); end
    end
    drain_all();
    checks++;
    if (out_valid !== 4'b0000 || xfer_cnt !== exp_cnt())
      begin errors++; $display("FAIL route_drain got v=%b c=%h want 0000/%h", out_valid, xfer_cnt, exp_cnt()); end
  endtask

  task automatic test_stall();
    set_in(2'd1, 1'b1, 8'h11, 4'b0000); tick();
    set_in(2'd1, 1'b1, 8'h55, 4'b0000);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ch1_ready got %b want 0", in_ready); end
    set_in(2'd2, 1'b1, 8'h55, 4'b0000);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ch2_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_data[23:16] !== 8'h55 || out_data[15:8] !== 8'h11 || out_valid !== 4'b0110)
      begin errors++; $display("FAIL stall_iso got d=%h v=%b want ..5511../0110", out_data, out_valid); end
    drain_all();
    set_in(2'd0, 1'b0, 8'h00, 4'b0000);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = m_cnt[0];
    for (int k = 1; k <= 16; k++) begin
      set_in(2'd0, 1'b1, 8'(k), 4'b0001);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got %b want 1", k, in_ready); end
      tick();
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'(k))
        begin errors++; $display("FAIL b2b_word k=%0d got v=%b d=%h want 1/%h", k, out_valid[0], out_data[7:0], 8'(k)); end
    end
    set_in(2'd0, 1'b0, 8'h00, 4'b0001);
    tick();
    checks++;
    if (xfer_cnt[7:0] !== 8'((c0 + 16) % 256) || out_valid[0] !== 1'b0)
      begin errors++; $display("FAIL b2b_count got %0d want %0d", xfer_cnt[7:0], (c0 + 16) % 256); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    set_in(2'd3, 1'b1, 8'h00, 4'b1000); tick();
    for (int n = 1; n <= 256; n++) begin
      set_in(2'd3, 1'b1, 8'($urandom), 4'b1000);
      tick();
      if (n == 255) begin
        checks++;
        if (xfer_cnt[31:24] !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", xfer_cnt[31:24]); end
      end
    end
    checks++;
    if (xfer_cnt !== 32'h0) begin errors++; $display("FAIL wrap_0 got %h want 00000000", xfer_cnt); end
    drain_all();
  endtask

  task automatic test_idle();
    logic [3:0]  v0;
    logic [31:0] d0, c0;
    set_in(2'd0, 1'b1, 8'h3C, 4'b0000); tick();
    set_in(2'd3, 1'b1, 8'hC3, 4'b0000); tick();
    v0 = exp_valid(); d0 = exp_data(); c0 = exp_cnt();
    for (int k = 0; k < 10; k++) begin
      set_in(2'($urandom), 1'b0, 8'($urandom), 4'b0000);
      tick();
      checks++;
      if (out_valid !== v0 || out_data !== d0 || xfer_cnt !== c0)
        begin errors++; $display("FAIL idle k=%0d got v=%b d=%h c=%h want %b/%h/%h", k, out_valid, out_data, xfer_cnt, v0, d0, c0); end
    end
    drain_all();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      set_in(2'($urandom), 1'($urandom), 8'($urandom), 4'($urandom));
      checks++;
      if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready k=%0d got %b want %b", k, in_ready, exp_ready()); end
      tick();
      checks++;
      if (out_valid !== exp_valid() || out_data !== exp_data() || xfer_cnt !== exp_cnt())
        begin errors++; $display("FAIL rand_out k=%0d got v=%b d=%h c=%h want %b/%h/%h", k, out_valid, out_data, xfer_cnt, exp_valid(), exp_data(), exp_cnt()); end
    end
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_routing();
    test_stall();
    test_back_to_back();
    test_idle();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
